// File: rtl/issue_queue_wakeup.sv
// Collapsing, age-ordered issue queue for one ALU. It tracks a ready bit per operand
// and wakes operands from CDB tag broadcasts. Slot 0 always holds the oldest entry.
// Optional flush port: define IQ_FLUSH_EN.
module issue_queue_wakeup #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned FUNC_WIDTH  = 4,
    parameter int unsigned TAG_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH   = $clog2(NUM_ENTRIES) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef IQ_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  load,
    input  logic [FUNC_WIDTH-1:0] insn,
    input  logic [TAG_WIDTH-1:0]  inp1,
    input  logic [TAG_WIDTH-1:0]  inp2,
    input  logic                  inp1_rdy,
    input  logic                  inp2_rdy,
    input  logic [TAG_WIDTH-1:0]  dst,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic                  issue,
    output logic                  issue_ready,
    output logic                  is_full,
    output logic [CNT_WIDTH-1:0]  count,
    output logic [FUNC_WIDTH-1:0] insn_out,
    output logic [TAG_WIDTH-1:0]  inp1_out,
    output logic [TAG_WIDTH-1:0]  inp2_out,
    output logic [TAG_WIDTH-1:0]  dst_out
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid_q, rdy1_q, rdy2_q;
    logic [FUNC_WIDTH-1:0]  insn_q [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   inp1_q [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   inp2_q [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   dst_q  [NUM_ENTRIES];
    logic [CNT_WIDTH-1:0]   count_q;

    logic [NUM_ENTRIES-1:0] valid_d, rdy1_d, rdy2_d, wake1, wake2;
    logic [FUNC_WIDTH-1:0]  insn_d [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   inp1_d [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   inp2_d [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   dst_d  [NUM_ENTRIES];
    logic [CNT_WIDTH-1:0]   count_d, ld_idx;
    logic [IDX_W-1:0]       sel_idx, src;
    logic                   sel_found, issue_acc, load_acc, ld_rdy1, ld_rdy2;

    // Oldest valid entry with both operands ready
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ready = sel_found;
    assign is_full     = (count_q == CNT_WIDTH'(NUM_ENTRIES));
    assign count       = count_q;
    assign insn_out    = sel_found ? insn_q[sel_idx] : '0;
    assign inp1_out    = sel_found ? inp1_q[sel_idx] : '0;
    assign inp2_out    = sel_found ? inp2_q[sel_idx] : '0;
    assign dst_out     = sel_found ? dst_q[sel_idx]  : '0;

    assign issue_acc = issue && sel_found;
    assign load_acc  = load && !is_full;
    assign ld_idx    = count_q - CNT_WIDTH'(issue_acc);
    assign ld_rdy1   = inp1_rdy || (inp1 == '0) || (cdb_valid && (cdb_tag == inp1));
    assign ld_rdy2   = inp2_rdy || (inp2 == '0) || (cdb_valid && (cdb_tag == inp2));
    assign count_d   = count_q + CNT_WIDTH'(load_acc) - CNT_WIDTH'(issue_acc);

    // Ready bits after this cycle's CDB broadcast
    always_comb begin
        wake1 = rdy1_q;
        wake2 = rdy2_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cdb_valid && (inp1_q[i] == cdb_tag)) wake1[i] = 1'b1;
            if (cdb_valid && (inp2_q[i] == cdb_tag)) wake2[i] = 1'b1;
        end
    end

    // Collapse over the issued slot, then append the dispatched entry at the tail
    always_comb begin
        valid_d = valid_q;
        rdy1_d  = wake1;
        rdy2_d  = wake2;
        insn_d  = insn_q;
        inp1_d  = inp1_q;
        inp2_d  = inp2_q;
        dst_d   = dst_q;
        src     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (issue_acc && (IDX_W'(i) >= sel_idx)) begin
                if (i < int'(NUM_ENTRIES) - 1) begin
                    src        = IDX_W'(i + 1);
                    valid_d[i] = valid_q[src];
                    rdy1_d[i]  = wake1[src];
                    rdy2_d[i]  = wake2[src];
                    insn_d[i]  = insn_q[src];
                    inp1_d[i]  = inp1_q[src];
                    inp2_d[i]  = inp2_q[src];
                    dst_d[i]   = dst_q[src];
                end else begin
                    valid_d[i] = 1'b0;
                    rdy1_d[i]  = 1'b0;
                    rdy2_d[i]  = 1'b0;
                end
            end
            if (load_acc && (CNT_WIDTH'(i) == ld_idx)) begin
                valid_d[i] = 1'b1;
                rdy1_d[i]  = ld_rdy1;
                rdy2_d[i]  = ld_rdy2;
                insn_d[i]  = insn;
                inp1_d[i]  = inp1;
                inp2_d[i]  = inp2;
                dst_d[i]   = dst;
            end
        end
    end

    // Queue state register; reset, then flush, take priority over normal updates
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                insn_q[i] <= '0;
                inp1_q[i] <= '0;
                inp2_q[i] <= '0;
                dst_q[i]  <= '0;
            end
`ifdef IQ_FLUSH_EN
        end else if (flush) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            count_q <= count_d;
            insn_q  <= insn_d;
            inp1_q  <= inp1_d;
            inp2_q  <= inp2_d;
            dst_q   <= dst_d;
        end
    end

endmodule

// File: tb/tb_issue_queue_wakeup.sv
// Randomized bench for issue_queue_wakeup. It compares the DUT against an age-ordered queue model.
module tb_issue_queue_wakeup;

    localparam int unsigned NE = 4;
    localparam int unsigned FW = 4;
    localparam int unsigned TW = 5;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset, load, inp1_rdy, inp2_rdy, cdb_valid, issue;
    logic [FW-1:0] insn;
    logic [TW-1:0] inp1, inp2, dst, cdb_tag;
`ifdef IQ_FLUSH_EN
    logic          flush;
`endif
    logic          issue_ready, is_full;
    logic [CW-1:0] count;
    logic [FW-1:0] insn_out;
    logic [TW-1:0] inp1_out, inp2_out, dst_out;

    always #5 clk = ~clk;

    issue_queue_wakeup #(.NUM_ENTRIES(NE), .FUNC_WIDTH(FW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
`ifdef IQ_FLUSH_EN
        .flush(flush),
`endif
        .load(load), .insn(insn), .inp1(inp1), .inp2(inp2),
        .inp1_rdy(inp1_rdy), .inp2_rdy(inp2_rdy), .dst(dst),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .issue(issue),
        .issue_ready(issue_ready), .is_full(is_full), .count(count),
        .insn_out(insn_out), .inp1_out(inp1_out), .inp2_out(inp2_out), .dst_out(dst_out)
    );

    typedef struct {
        logic [FW-1:0] f;
        logic [TW-1:0] a, b, d;
        bit            r1, r2;
    } ent_t;

    ent_t mq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs against the oldest fully ready model entry
    task automatic check_outputs();
        int sel;
        logic [31:0] ef, ea, eb, ed;
        sel = -1;
        ef = 0; ea = 0; eb = 0; ed = 0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) begin
                sel = i;
                break;
            end
        end
        if (sel >= 0) begin
            ef = 32'(mq[sel].f);
            ea = 32'(mq[sel].a);
            eb = 32'(mq[sel].b);
            ed = 32'(mq[sel].d);
        end
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("is_full", 32'(is_full), 32'(mq.size() == NE));
        check_eq("issue_ready", 32'(issue_ready), 32'(sel >= 0));
        check_eq("insn_out", 32'(insn_out), ef);
        check_eq("inp1_out", 32'(inp1_out), ea);
        check_eq("inp2_out", 32'(inp2_out), eb);
        check_eq("dst_out", 32'(dst_out), ed);
    endtask

    // Apply one clock edge of behaviour to the model from the currently driven inputs
    task automatic model_step();
        int   sel;
        bit   iss, ld;
        ent_t e;
        if (!reset) begin
            mq.delete();
            return;
        end
`ifdef IQ_FLUSH_EN
        if (flush) begin
            mq.delete();
            return;
        end
`endif
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) begin
                sel = i;
                break;
            end
        end
        iss = issue && (sel >= 0);
        ld  = load && (mq.size() < NE);
        if (cdb_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].a == cdb_tag) mq[i].r1 = 1'b1;
                if (mq[i].b == cdb_tag) mq[i].r2 = 1'b1;
            end
        end
        if (iss) mq.delete(sel);
        if (ld) begin
            e.f  = insn;
            e.a  = inp1;
            e.b  = inp2;
            e.d  = dst;
            e.r1 = inp1_rdy || (inp1 == 0) || (cdb_valid && cdb_tag == inp1);
            e.r2 = inp2_rdy || (inp2 == 0) || (cdb_valid && cdb_tag == inp2);
            mq.push_back(e);
        end
    endtask

    // Drive one cycle at negedge, advance the model, then check after the edge
    task automatic cyc(input bit rn, input bit ld, input logic [FW-1:0] f,
                       input logic [TW-1:0] a, input logic [TW-1:0] b, input logic [TW-1:0] d,
                       input bit ra, input bit rb, input bit cv, input logic [TW-1:0] ct,
                       input bit is);
        reset = rn; load = ld; insn = f; inp1 = a; inp2 = b; dst = d;
        inp1_rdy = ra; inp2_rdy = rb; cdb_valid = cv; cdb_tag = ct; issue = is;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit is);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, is);
    endtask

    initial begin
`ifdef IQ_FLUSH_EN
        flush = 1'b0;
`endif
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single ADD: offered next cycle, then issued
        cyc(1, 1, 4'h1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 0);
        check_eq("t1_dst", 32'(dst_out), 32'd3);
        idle(1);
        check_eq("t1_empty", 32'(count), 32'd0);

        // Fill to capacity, a 5th load is dropped, drain in order
        cyc(1, 1, 4'h2, 5'd1, 5'd1, 5'd3, 1, 1, 0, 0, 0);
        cyc(1, 1, 4'h3, 5'd1, 5'd1, 5'd6, 1, 1, 0, 0, 0);
        cyc(1, 1, 4'h4, 5'd1, 5'd1, 5'd10, 1, 1, 0, 0, 0);
        cyc(1, 1, 4'h5, 5'd1, 5'd1, 5'd18, 1, 1, 0, 0, 0);
        cyc(1, 1, 4'h6, 5'd1, 5'd1, 5'd30, 1, 1, 0, 0, 0);
        check_eq("t2_full", 32'(is_full), 32'd1);
        repeat (4) idle(1);

        // Older blocked entry is bypassed, then woken by CDB
        cyc(1, 1, 4'h7, 5'd7, 5'd0, 5'd8, 0, 1, 0, 0, 0);
        cyc(1, 1, 4'h8, 5'd1, 5'd2, 5'd9, 1, 1, 0, 0, 0);
        check_eq("t3_young", 32'(dst_out), 32'd9);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
        check_eq("t3_woken", 32'(dst_out), 32'd8);
        idle(1);
        idle(1);

        // Wakeup bypass on the load cycle
        cyc(1, 1, 4'h9, 5'd0, 5'd12, 5'd13, 1, 0, 1, 5'd12, 0);
        check_eq("t4_bypass", 32'(issue_ready), 32'd1);
        idle(1);

        // Simultaneous load and issue at count=2
        cyc(1, 1, 4'h1, 5'd1, 5'd1, 5'd4, 1, 1, 0, 0, 0);
        cyc(1, 1, 4'h2, 5'd9, 5'd1, 5'd5, 0, 1, 0, 0, 0);
        cyc(1, 1, 4'h3, 5'd1, 5'd1, 5'd6, 1, 1, 0, 0, 1);
        check_eq("t5_count", 32'(count), 32'd2);

        // Reset while full
        cyc(1, 1, 4'h4, 5'd1, 5'd1, 5'd7, 1, 1, 0, 0, 0);
        cyc(1, 1, 4'h5, 5'd1, 5'd1, 5'd8, 1, 1, 0, 0, 0);
        cyc(0, 1, 4'h6, 5'd1, 5'd1, 5'd9, 1, 1, 1, 5'd9, 1);
        check_eq("t6_rst_cnt", 32'(count), 32'd0);

        // Random traffic with a small tag space so wakeups collide often
        for (int n = 0; n < 3000; n++) begin
`ifdef IQ_FLUSH_EN
            flush = ($urandom_range(0, 49) == 0);
`endif
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6),
                FW'($urandom), TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7)),
                TW'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) < 4), TW'($urandom_range(0, 7)),
                ($urandom_range(0, 9) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
